// File: rtl/mont_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mont_mul_arbiter
// Brief    : Round-robin arbiter sharing one Montgomery multiplier between
//            N_REQ requesters, with operand latching, result capture and an
//            optional watchdog on the multiplier's done.
// Revision : 1.0 - initial release
// ============================================================================
module mont_mul_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 512,
    parameter int TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    input  logic [N_REQ*WIDTH-1:0] op_m,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   err,
    output logic [WIDTH-1:0]       result,
    output logic                   busy,
    output logic                   mont_resetn,
    output logic                   mont_start,
    output logic [WIDTH-1:0]       mont_a,
    output logic [WIDTH-1:0]       mont_b,
    output logic [WIDTH-1:0]       mont_m,
    input  logic [WIDTH-1:0]       mont_result,
    input  logic                   mont_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     g_q, g_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WW-1:0]     wdog_q, wdog_d;

    logic [PW-1:0]     pick;
    logic              pick_vld;
    logic              wd_expire;

    // Round-robin pick: first requester after ptr, wrapping modulo N_REQ.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (req[idx]) begin
                pick     = PW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // Watchdog fires on the last allowed WAIT cycle; TIMEOUT of 0 disables it.
    assign wd_expire = (TIMEOUT != 0) && (wdog_q == WW'(TIMEOUT - 1));

    // Next-state and datapath updates for the arbitration sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        g_d      = g_q;
        gnt_d    = gnt_q;
        err_d    = err_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        wdog_d   = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    g_d     = pick;
                    gnt_d   = N_REQ'(1) << pick;
                    a_d     = op_a[int'(pick)*WIDTH +: WIDTH];
                    b_d     = op_b[int'(pick)*WIDTH +: WIDTH];
                    m_d     = op_m[int'(pick)*WIDTH +: WIDTH];
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            // Extra cleared cycle so the multiplier sees new operands under reset.
            S_LOAD: state_d = S_START;
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mont_done) begin
                    result_d = mont_result;
                    state_d  = S_RESP;
                end else if (wd_expire) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            S_RESP: begin
                ptr_d   = g_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= PW'(N_REQ - 1);
            g_q      <= '0;
            gnt_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            g_q      <= g_d;
            gnt_q    <= gnt_d;
            err_q    <= err_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            wdog_q   <= wdog_d;
        end
    end

    // Control outputs decode directly from the registered state.
    assign busy        = (state_q != S_IDLE);
    assign mont_start  = (state_q == S_START);
    assign mont_resetn = (state_q == S_START) || (state_q == S_WAIT);
    assign ack         = (state_q == S_RESP) ? gnt_q : '0;
    assign err         = (state_q == S_RESP) && err_q;
    assign gnt         = gnt_q;
    assign result      = result_q;
    assign mont_a      = a_q;
    assign mont_b      = b_q;
    assign mont_m      = m_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mont_mul_arbiter
// Brief    : Directed self-checking bench for mont_mul_arbiter with a small
//            multiplier model (done 10 cycles after start).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mont_mul_arbiter;

    localparam int N_REQ   = 2;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [WIDTH-1:0]       a0 = '0, b0 = '0, m0 = '0, a1 = '0, b1 = '0, m1 = '0;
    logic [N_REQ*WIDTH-1:0] op_a, op_b, op_m;
    logic [N_REQ-1:0]       gnt, ack;
    logic                   err, busy, mont_resetn, mont_start, mont_done;
    logic [WIDTH-1:0]       result, mont_a, mont_b, mont_m, mont_result;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;

    logic model_en = 1'b1;
    logic spur     = 1'b0;
    int   mcnt;

    assign op_a = {a1, a0};
    assign op_b = {b1, b0};
    assign op_m = {m1, m0};

    mont_mul_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req),
        .op_a(op_a), .op_b(op_b), .op_m(op_m),
        .gnt(gnt), .ack(ack), .err(err), .result(result), .busy(busy),
        .mont_resetn(mont_resetn), .mont_start(mont_start),
        .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done)
    );

    always #5 clk = ~clk;

    // Multiplier model: done pulses 10 cycles after the start cycle.
    always @(posedge clk or posedge reset) begin
        if (reset)           mcnt <= 0;
        else if (mont_start) mcnt <= 10;
        else if (mcnt > 0)   mcnt <= mcnt - 1;
    end
    assign mont_done   = (model_en && (mcnt == 1)) || spur;
    assign mont_result = (mont_a == 16'd9) ? 16'hBEEF : 16'h1234;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_ack(output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (ack == '0 && c < 200);
        if (ack == '0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_start(output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (!mont_start && c < 200);
        if (!mont_start) chk("start_timeout", 32'd0, 32'd1);
    endtask

    // Every start after the first must be preceded by a cleared multiplier cycle.
    logic had_start = 1'b0, seen_low = 1'b0;
    always @(negedge clk) begin
        if (mont_start) begin
            if (had_start) chk("rstn_gap", {31'd0, seen_low}, 32'd1);
            had_start = 1'b1;
            seen_low  = 1'b0;
        end else if (!mont_resetn) begin
            seen_low = 1'b1;
        end
    end

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_gnt",   gnt,         0);
        chk("rst_ack",   ack,         0);
        chk("rst_err",   err,         0);
        chk("rst_busy",  busy,        0);
        chk("rst_rstn",  mont_resetn, 0);
        chk("rst_start", mont_start,  0);
        chk("rst_res",   result,      0);
        chk("rst_a",     mont_a,      0);

        // Single request from requester 0.
        @(negedge clk);
        reset = 1'b0;
        req = 2'b01; a0 = 16'd3; b0 = 16'd5; m0 = 16'd7;
        a1 = 16'd9; b1 = 16'd2; m1 = 16'd11;
        @(negedge clk);
        chk("t1_gnt",  gnt,         2'b01);
        chk("t1_busy", busy,        1);
        chk("t1_rstn", mont_resetn, 0);
        chk("t1_a",    mont_a,      3);
        chk("t1_b",    mont_b,      5);
        chk("t1_m",    mont_m,      7);
        a0 = 16'd4;
        @(negedge clk);
        chk("t1_start",   mont_start,  1);
        chk("t1_rstn2",   mont_resetn, 1);
        chk("t1_a_held",  mont_a,      3);
        a0 = 16'd3;
        cyc = 0;
        while (!mont_done && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t1_done_lat", cyc,    10);
        chk("t1_res_pre",  result, 0);
        @(negedge clk);
        chk("t1_ack", ack,    2'b01);
        chk("t1_res", result, 16'h1234);
        chk("t1_err", err,    0);
        req = 2'b00;
        @(negedge clk);
        chk("t1_idle", busy, 0);
        chk("t1_ack0", ack,  0);

        // Round-robin with both requests held after a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc);
            chk("rr_ack", ack,    (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_res", result, (k % 2 == 0) ? 16'h1234 : 16'hBEEF);
            if (k == 0) begin
                @(negedge clk);
                @(negedge clk);
                chk("rr_gnt1", gnt,    2'b10);
                chk("rr_a1",   mont_a, 9);
            end
        end
        req = 2'b00;

        // Watchdog abort: the model never answers.
        model_en = 1'b0;
        req = 2'b01;
        wait_start(cyc);
        wait_ack(cyc);
        chk("wd_lat", cyc,    17);
        chk("wd_ack", ack,    2'b01);
        chk("wd_err", err,    1);
        chk("wd_res", result, 0);
        req = 2'b00;
        @(negedge clk);
        chk("wd_idle", busy,        0);
        chk("wd_rstn", mont_resetn, 0);
        chk("wd_err0", err,         0);
        model_en = 1'b1;

        // Spurious done in IDLE and in START is ignored.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("sp_idle_busy", busy,   0);
        chk("sp_idle_res",  result, 0);
        req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("sp_start", mont_start, 1);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("sp_wait_busy", busy,        1);
        chk("sp_wait_rstn", mont_resetn, 1);
        chk("sp_wait_ack",  ack,         0);
        chk("sp_wait_res",  result,      0);
        wait_ack(cyc);
        chk("sp_ack", ack,    2'b01);
        chk("sp_res", result, 16'h1234);
        req = 2'b00;

        // Asynchronous reset while waiting on the multiplier.
        @(negedge clk);
        req = 2'b01;
        wait_start(cyc);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("ar_busy_pre", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_gnt",  gnt,         0);
        chk("ar_busy", busy,        0);
        chk("ar_rstn", mont_resetn, 0);
        chk("ar_a",    mont_a,      0);
        chk("ar_res",  result,      0);
        chk("ar_ack",  ack,         0);
        req = 2'b10;
        @(negedge clk);
        chk("ar_ack_hold", ack, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ar_gnt_after", gnt, 2'b10);
        wait_ack(cyc);
        chk("ar_ack_after", ack,    2'b10);
        chk("ar_res_after", result, 16'hBEEF);
        req = 2'b00;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
